// File: rtl/ram_ctrl_pkg.sv
// Shared types and width helpers for the pipelined RAM controller.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);

  localparam int unsigned DEPTH_WORDS_DEF = 65536;
  localparam int unsigned RD_LAT_DEF      = 2;
  localparam int unsigned RESP_DEPTH_DEF  = 4;
  localparam int unsigned IDX_W_DEF       = $clog2(DEPTH_WORDS_DEF);

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              write;
    logic              err;
  } resp_t;

  function automatic int unsigned idx_width(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

  // Counter able to hold 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ram_ctrl_pipe_if.sv
// Request/response handshake bundle between a memory client and ram_ctrl_pipe.
interface ram_ctrl_pipe_if;
  import ram_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BYTES-1:0]  req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_write;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );
endinterface

// File: rtl/ram_resp_fifo.sv
// Synchronous response FIFO; caller guarantees no push when full, no pop when empty.
module ram_resp_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output resp_t pop_data,
  output logic  empty,
  output logic  full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  resp_t             store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) store[wr_ptr] <= push_data;
  end

  assign pop_data = store[rd_ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/ram_ctrl_pipe.sv
// Word-array memory behind a valid/ready port with fixed read latency and credit-limited
// in-order responses. Define RAM_RANGE_CHECK_EN to flag and drop out-of-window accesses.
module ram_ctrl_pipe
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned       RD_LAT      = RD_LAT_DEF,
  parameter int unsigned       RESP_DEPTH  = RESP_DEPTH_DEF
) (
  input logic           clock,
  input logic           reset,
  ram_ctrl_pipe_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
  localparam int unsigned CNT_W = cnt_width(RESP_DEPTH);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] offs;
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  count;
  resp_t             stage_in;
  resp_t             pipe_q [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld;
  resp_t             head;
  logic              fifo_empty;
  logic              fifo_full;

  assign offs   = bus.req_addr - BASE_ADDR;
  assign idx    = IDX_W'(offs >> OFF_W);
  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = bus.resp_valid && bus.resp_ready;

`ifdef RAM_RANGE_CHECK_EN
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS) << OFF_W;
  assign addr_err = (bus.req_addr < BASE_ADDR) || (offs >= SPAN);

  always_ff @(posedge clock) begin
    if (!reset && accept && addr_err)
      $error("ram_ctrl_pipe: address out of range 0x%h", bus.req_addr);
  end
`else
  assign addr_err = 1'b0;
`endif

  // Byte-strobed commit at the accept edge; array is intentionally not reset.
  always_ff @(posedge clock) begin
    if (accept && bus.req_write && !addr_err) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (bus.req_wstrb[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    stage_in.rdata = '0;
    stage_in.write = bus.req_write;
    stage_in.err   = addr_err;
    if (!bus.req_write && !addr_err) stage_in.rdata = mem[idx];
  end

  // Payload stages free-run; only the valid bits need reset.
  always_ff @(posedge clock) begin
    pipe_q[0] <= stage_in;
    for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) pipe_vld <= '0;
    else       pipe_vld <= RD_LAT'({pipe_vld, accept});
  end

  // Credits cover pipeline plus FIFO, so neither can ever overflow.
  always_ff @(posedge clock) begin
    if (reset)                count <= '0;
    else if (accept && !pop)  count <= count + CNT_W'(1);
    else if (pop && !accept)  count <= count - CNT_W'(1);
  end

  assign bus.req_ready = !reset && (count < CNT_W'(RESP_DEPTH));

  ram_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pipe_vld[RD_LAT-1]),
    .push_data (pipe_q[RD_LAT-1]),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clock) begin
    if (!reset) assert (!(pipe_vld[RD_LAT-1] && fifo_full));
  end

  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_rdata = head.rdata;
  assign bus.resp_write = head.write;
  assign bus.resp_err   = head.err;

endmodule

// File: tb/tb_ram_ctrl_pipe.sv
// Randomized and directed checks of ram_ctrl_pipe against a queue/array reference model.
module tb_ram_ctrl_pipe;
  import ram_ctrl_pkg::*;

  localparam logic [63:0] BASE       = 64'h8000_0000;
  localparam int unsigned DEPTH      = 65536;
  localparam int unsigned LAT        = 2;
  localparam int unsigned RDEPTH     = 4;

  typedef struct {
    logic [63:0] rdata;
    logic        write;
    logic        err;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  ram_ctrl_pipe_if bus ();

  ram_ctrl_pipe #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .RD_LAT      (LAT),
    .RESP_DEPTH  (RDEPTH)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          chk_lat = 1'b0;
  logic [63:0] last_rdata = '0;
  logic [63:0] mdl [int unsigned];
  exp_t        expq [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int unsigned mdl_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return 32'((off / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic logic mdl_err(input logic [63:0] a);
`ifdef RAM_RANGE_CHECK_EN
    return (a < BASE) || (a >= BASE + 64'(DEPTH) * 64'd8);
`else
    return 1'b0 & a[0];
`endif
  endfunction

  function automatic logic [63:0] pool(input int k);
    return BASE + 64'h100 + 64'(8 * k);
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: applies requests in accept order, checks responses in that same order.
  always @(negedge clk) begin
    exp_t e;
    int unsigned i;
    logic [63:0] w;
    if (reset) begin
      expq.delete();
    end else begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (expq.size() == 0) begin
          check("resp_unexpected", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_write", 64'(bus.resp_write), 64'(e.write));
          check("resp_err", 64'(bus.resp_err), 64'(e.err));
          if (chk_lat) check("latency", 64'(cyc - e.acc_cyc - 1), 64'(LAT));
          if (!e.write) last_rdata = bus.resp_rdata;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        i = mdl_idx(bus.req_addr);
        e.write   = bus.req_write;
        e.err     = mdl_err(bus.req_addr);
        e.acc_cyc = cyc;
        e.rdata   = '0;
        w = mdl.exists(i) ? mdl[i] : 64'h0;
        if (bus.req_write) begin
          if (!e.err) begin
            for (int b = 0; b < 8; b++)
              if (bus.req_wstrb[b]) w[8*b +: 8] = bus.req_wdata[8*b +: 8];
            mdl[i] = w;
          end
        end else if (!e.err) begin
          e.rdata = w;
        end
        expq.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    bit done = 1'b0;
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    while (!done && n < 100) begin
      @(negedge clk);
      done = bus.req_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.resp_ready = 1'b1;
    while ((expq.size() != 0 || bus.resp_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit took;
    logic [63:0] d;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;   bus.resp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready_low", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_req_ready_high", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;

    // Full write then back-to-back read, then partial-strobe overwrite
    chk_lat = 1'b1;
    issue(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF);
    issue(1'b0, 64'h8000_0010, '0, '0);
    wait_idle();
    check("raw_full", last_rdata, 64'h1122334455667788);
    issue(1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    issue(1'b0, 64'h8000_0010, '0, '0);
    wait_idle();
    check("raw_strobe", last_rdata, 64'h11223344AAAAAAAA);
    issue(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    issue(1'b0, 64'h8000_0010, '0, '0);
    wait_idle();
    check("zero_strobe", last_rdata, 64'h11223344AAAAAAAA);

    for (int k = 0; k < 16; k++) issue(1'b1, pool(k), {$urandom, $urandom}, 8'hFF);
    wait_idle();

    // Sustained throughput with resp_ready high
    acc = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = pool(0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk); #1;
      bus.req_addr = pool(c + 1);
    end
    bus.req_valid = 1'b0;
    check("throughput", 64'(acc), 64'd8);
    wait_idle();
    chk_lat = 1'b0;

    // Backpressure: six reads offered, four credits
    bus.resp_ready = 1'b0;
    acc = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = pool(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk); #1;
      if (acc < 6) bus.req_addr = pool(acc); else bus.req_valid = 1'b0;
    end
    check("bp_accepted", 64'(acc), 64'd4);
    @(negedge clk);
    check("bp_ready_low", 64'(bus.req_ready), 64'd0);
    check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc++;
      @(posedge clk); #1;
      if (acc < 6) bus.req_addr = pool(acc); else bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("bp_all_accepted", 64'(acc), 64'd6);
    wait_idle();

    // Simultaneous accept and pop at three outstanding
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) issue(1'b0, pool(k + 3), '0, '0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = pool(7);
    @(negedge clk);
    check("sim_pre_ready", 64'(bus.req_ready), 64'd1);
    check("sim_pre_valid", 64'(bus.resp_valid), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("sim_ready_hold", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    issue(1'b0, pool(8), '0, '0);
    @(negedge clk);
    check("sim_count_full", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    wait_idle();

    // Reset with requests in flight; committed data survives
    bus.resp_ready = 1'b0;
    issue(1'b1, pool(9), 64'h0123_4567_89AB_CDEF, 8'hFF);
    issue(1'b0, pool(1), '0, '0);
    issue(1'b0, pool(2), '0, '0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) issue(1'b0, pool(9), '0, '0);
    @(negedge clk);
    check("midrst_count", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    wait_idle();
    check("midrst_data", last_rdata, 64'h0123_4567_89AB_CDEF);

    // Address below the window
    d = 64'h5A5A_0000_1234_5678;
    issue(1'b1, 64'h8000_0000, 64'h0BAD_F00D_0000_0001, 8'hFF);
    issue(1'b1, 64'h7FFF_FFF8, d, 8'hFF);
    issue(1'b0, 64'h8000_0000, '0, '0);
    wait_idle();
    check("range_word0", last_rdata, 64'h0BAD_F00D_0000_0001);
`ifndef RAM_RANGE_CHECK_EN
    issue(1'b0, BASE + 64'(DEPTH - 1) * 64'd8, '0, '0);
    wait_idle();
    check("range_wrap", last_rdata, d);
`endif

    // Random traffic over the initialized pool
    for (int c = 0; c < 600; c++) begin
      if (!bus.req_valid && ($urandom % 10 < 7)) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'($urandom % 2);
        bus.req_addr  = pool(int'($urandom % 16));
        bus.req_wdata = {$urandom, $urandom};
        bus.req_wstrb = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
      end
      bus.resp_ready = ($urandom % 4 != 0);
      @(negedge clk);
      took = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (took) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("final_resp_valid", 64'(bus.resp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_ctrl_pipe.md
Name: ram_ctrl_pipe

Overview:
- Parametrised successor to the single-cycle RAM control block; memory behind a valid/ready request/response interface.
- Internal word array, byte-strobed writes, configurable read latency, in-order responses.
- Response FIFO absorbs consumer backpressure; credit counter throttles requests.
- Sits between the core's LSU/IFU memory port and simulated main memory in the npc playground.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, data width; multiple of 8, power of two.
- DEPTH_WORDS, 65536, array depth in DATA_W words; power of two.
- BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.
- RD_LAT, 2, cycles from request accept to response entering the FIFO; range 1..8.
- RESP_DEPTH, 4, response FIFO depth and maximum outstanding requests; at least 2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables; bit i controls byte i.
- resp_valid  out  1  response at FIFO head.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  read data; 0 for writes.
- resp_write  out  1  echoes req_write of the matching request.
- resp_err  out  1  address error (see Optional Feature).

Behaviour:
- Reset, synchronous and active-high:
  - Clears resp_valid, the pipeline valid bits, the outstanding counter and the FIFO pointers.
  - req_ready is 0 while reset is high.
  - Array contents are not reset.
  - Reset mid-operation drops all in-flight responses; writes already committed remain in the array.
- Accept: req_valid && req_ready at a rising edge.
- Index: idx = (req_addr - BASE_ADDR) >> log2(DATA_W/8), truncated to log2(DEPTH_WORDS) bits.
- Write:
  - Committed at the accept edge, byte i only where req_wstrb[i] = 1.
  - wstrb = 0 is legal: no change, but an ack is still returned.
- Read:
  - Data sampled from the array at the accept edge.
  - A request accepted on the following cycle observes any write committed on the previous accept (read-after-write coherent).
- Pipeline:
  - Every accepted request, read or write, travels RD_LAT stages of {rdata, write, err} with a valid bit.
  - It is pushed into the FIFO on the cycle its stage RD_LAT is valid.
  - With an idle FIFO, resp_valid rises exactly RD_LAT cycles after the accept edge.
- Ordering: responses strictly in request order; no reordering between reads and writes.
- Credit counter (0..RESP_DEPTH):
  - +1 on accept, -1 on response handshake (resp_valid && resp_ready), unchanged when both occur in the same cycle.
  - req_ready = !reset && (count < RESP_DEPTH).
  - The FIFO therefore can never overflow and pipeline stages never stall.
- Full: at count == RESP_DEPTH, req_ready = 0 combinationally. A pop in the same cycle does not re-enable req_ready until the next cycle, so there is no combinational path from resp_ready to req_ready.
- Empty: resp_valid = 0 and the outputs hold their last values (don't-care).
- Throughput: one request per cycle sustained when resp_ready is held high.

Optional Feature:
- Macro: RAM_RANGE_CHECK_EN.
- Defined:
  - An address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*DATA_W/8) suppresses the write.
  - The response for that request returns resp_err = 1 and resp_rdata = 0.
  - A simulation $error is printed with the address.
- Not defined:
  - No range comparison; idx wraps modulo DEPTH_WORDS.
  - resp_err is tied to 0.

Decomposition:
- Package ram_ctrl_pkg:
  - resp_t struct {rdata, write, err}.
  - Width helpers: BYTES = DATA_W/8, OFF_W = log2(BYTES), IDX_W = log2(DEPTH_WORDS).
  - Counter width function clog2(RESP_DEPTH+1).
- Sub-module ram_resp_fifo:
  - Synchronous FIFO of resp_t, depth RESP_DEPTH.
  - push/pop interface, pointer wrap, full/empty flags.
  - Instantiated once.

Test Plan:
- Write 0x1122334455667788 with wstrb 0xFF at 0x8000_0010, then read the same address on the next cycle -> read response 0x1122334455667788, resp_write = 0, arriving RD_LAT = 2 cycles after accept.
- Write 0xAAAA_AAAA_AAAA_AAAA with wstrb 0x0F over the previous data, then read -> 0x11223344AAAAAAAA.
- resp_ready held 0 with 6 back-to-back reads offered -> exactly 4 accepted, then req_ready = 0. Raise resp_ready -> 4 responses in order, then the remaining 2 are accepted.
- Simultaneous accept and pop at count = 3 with resp_ready = 1 -> count stays 3, req_ready stays 1, no lost or duplicated response.
- Assert reset for 1 cycle with 3 requests in flight -> resp_valid = 0 next cycle, count = 0, and a subsequent read of a written address returns the committed data.
- With RAM_RANGE_CHECK_EN, write to 0x7FFF_FFF8 then read 0x8000_0000 -> write response resp_err = 1, word 0 unchanged. Without the macro, the same write lands at idx DEPTH_WORDS-1 and resp_err = 0.
